// File: rtl/vga_timing_480p.sv
// 640x480@60 VGA raster timing generator: counts pixels/lines while the pixel clock
// is locked and emits registered sync, data-enable, coordinates and start strobes.
module vga_timing_480p #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   CORDW    = 10
) (
    input  logic             sysClock,
    input  logic             reset,
    input  logic             pixel_locked,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             line_start,
    output logic             frame_start,
    output logic             running
);

    localparam logic [CORDW-1:0] H_LAST = CORDW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CORDW-1:0] V_LAST = CORDW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_ACTIVE);
    localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_ACTIVE);
    localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_ACTIVE + H_FP);
    localparam logic [CORDW-1:0] HS_END = CORDW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_ACTIVE + V_FP);
    localparam logic [CORDW-1:0] VS_END = CORDW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CORDW-1:0] ONE    = CORDW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CORDW-1:0] sx_q, sx_d, sy_q, sy_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic             line_q, line_d, frame_q, frame_d, run_q, run_d;

    // Next-state and next-output decode; outputs derive from the next coordinates so
    // every registered output stays consistent with the registered sx/sy.
    always_comb begin
        state_d = state_q;
        sx_d    = '0;
        sy_d    = '0;
        case (state_q)
            IDLE: begin
                if (pixel_locked) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!pixel_locked) begin
                    state_d = IDLE;
                end else if (sx_q == H_LAST) begin
                    sx_d = '0;
                    if (sy_q == V_LAST) begin
                        sy_d = '0;
                    end else begin
                        sy_d = sy_q + ONE;
                    end
                end else begin
                    sx_d = sx_q + ONE;
                    sy_d = sy_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        run_d   = (state_d == RUN);
        de_d    = run_d && (sx_d < H_ACT) && (sy_d < V_ACT);
        hsync_d = (run_d && (sx_d >= HS_BEG) && (sx_d <= HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d = (run_d && (sy_d >= VS_BEG) && (sy_d <= VS_END)) ? SYNC_POL : ~SYNC_POL;
        line_d  = run_d && (sx_d == '0);
        frame_d = line_d && (sy_d == '0);
    end

    // State, counter and output registers; reset outranks lock and counting.
    always_ff @(posedge sysClock) begin
        if (reset) begin
            state_q <= IDLE;
            sx_q    <= '0;
            sy_q    <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            de_q    <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            line_q  <= line_d;
            frame_q <= frame_d;
            run_q   <= run_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign sx          = sx_q;
    assign sy          = sy_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;
    assign running     = run_q;

endmodule
